// File: rtl/axis_spi_dac_multi.sv
// Multi-channel AD5791-class SPI DAC driver: shared SCLK/SYNC, one SDI per channel.
// Stream path with latest-sample-wins buffering, config path, frame/drop counters.
module axis_spi_dac_multi #(
  parameter int NUM_DAC = 4,
  parameter int DAC_DATA_WIDTH = 20,
  parameter int DAC_WORD_WIDTH = 24,
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter logic [DAC_WORD_WIDTH-DAC_DATA_WIDTH-1:0] CMD_PREFIX = 4'b0001,
  parameter int CLK_DIV = 4,
  parameter int SYNC_GAP = 2,
  parameter bit SKIP_UNCHANGED = 1'b1
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic [NUM_DAC*SAXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic [NUM_DAC*DAC_WORD_WIDTH-1:0] cfg_tdata,
  input  logic cfg_tvalid,
  input  logic configuration_mode,
  input  logic configuration_send,
  output logic dac_sclk,
  output logic dac_sync_n,
  output logic [NUM_DAC-1:0] dac_sdi,
  output logic busy,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int WW = DAC_WORD_WIDTH;
  localparam int DW = DAC_DATA_WIDTH;
  localparam int SW = SAXIS_TDATA_WIDTH;
  localparam int NW = NUM_DAC * WW;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WW);
  localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CW-1:0] r_div_cnt;
  logic [CW-1:0] w_div_nxt;
  logic r_sclk;
  logic w_rise;

  logic r_sync_n;
  logic [NUM_DAC-1:0] r_sdi;
  logic [NW-1:0] r_sh;
  logic [BW-1:0] r_bitcnt;
  logic [GW-1:0] r_gapcnt;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  logic [NW-1:0] r_pend_words;
  logic r_pend_valid;
  logic [NW-1:0] r_cfg_buf;
  logic r_cfg_pending;
  logic r_send_d;
  logic [NW-1:0] r_last_sent;

  logic w_tready;
  logic w_accept;
  logic w_send_rise;
  logic [NW-1:0] w_s_words;

  logic w_idle_like;
  logic w_take_cfg;
  logic w_take_strm;
  logic w_load;
  logic w_shift;
  logic w_end;
  logic w_gap_dec;
  logic [NW-1:0] w_sel_words;

  logic [NW-1:0] w_ld_sh;
  logic [NUM_DAC-1:0] w_ld_msb;
  logic [NW-1:0] w_sh_nxt;
  logic [NUM_DAC-1:0] w_sh_msb;

  logic w_unused;

  assign w_unused = ^s_axis_tdata;

  assign w_div_nxt = (r_div_cnt == DIV_LAST) ?
                     '0 : r_div_cnt + CW'(1);
  assign w_rise = (w_div_nxt == DIV_HALF);

  assign w_tready = !a_rst && !configuration_mode;
  assign w_accept = s_axis_tvalid && w_tready;
  assign w_send_rise = configuration_send && !r_send_d;

  assign s_axis_tready = w_tready;
  assign dac_sclk = r_sclk;
  assign dac_sync_n = r_sync_n;
  assign dac_sdi = r_sdi;
  assign busy = (r_state != IDLE);
  assign frame_count = r_frame_cnt;
  assign drop_count = r_drop_cnt;

  // Code bits come from the top of each sample, prefixed with the write command.
  always_comb begin
    w_s_words = '0;
    for (int k = 0; k < NUM_DAC; k++) begin
      w_s_words[k*WW +: WW] =
        {CMD_PREFIX, s_axis_tdata[k*SW + SW-1 -: DW]};
    end
  end

  always_comb begin
    w_ld_sh = '0;
    w_ld_msb = '0;
    w_sh_nxt = '0;
    w_sh_msb = '0;
    for (int k = 0; k < NUM_DAC; k++) begin
      w_ld_msb[k] = w_sel_words[k*WW + WW-1];
      w_ld_sh[k*WW +: WW] = {w_sel_words[k*WW +: WW-1], 1'b0};
      w_sh_msb[k] = r_sh[k*WW + WW-1];
      w_sh_nxt[k*WW +: WW] = {r_sh[k*WW +: WW-1], 1'b0};
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // The last GAP tick doubles as an IDLE tick so back-to-back frames
  // keep the sync gap at exactly SYNC_GAP SCLK periods.
  always_comb begin
    w_nxt = r_state;
    w_take_cfg = 1'b0;
    w_take_strm = 1'b0;
    w_load = 1'b0;
    w_shift = 1'b0;
    w_end = 1'b0;
    w_gap_dec = 1'b0;
    w_sel_words = r_cfg_buf;
    w_idle_like = (r_state == IDLE) ||
                  (r_state == GAP && r_gapcnt == '0);
    unique case (r_state)
      IDLE: begin
      end
      LOAD, SHIFT: begin
        if (w_rise) begin
          if (r_bitcnt != '0) begin
            w_shift = 1'b1;
            w_nxt = SHIFT;
          end else begin
            w_end = 1'b1;
            w_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (w_rise) begin
          if (r_gapcnt != '0) begin
            w_gap_dec = 1'b1;
          end else begin
            w_nxt = IDLE;
          end
        end
      end
      default: w_nxt = IDLE;
    endcase
    if (w_rise && w_idle_like) begin
      if (configuration_mode && r_cfg_pending) begin
        w_take_cfg = 1'b1;
        w_sel_words = r_cfg_buf;
        w_load = 1'b1;
      end else if (!configuration_mode && r_pend_valid) begin
        w_take_strm = 1'b1;
        w_sel_words = r_pend_words;
        w_load = !(SKIP_UNCHANGED &&
                   (r_pend_words == r_last_sent));
      end
      if (w_load) begin
        w_nxt = LOAD;
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_div_cnt <= '0;
      r_sclk <= 1'b0;
      r_sync_n <= 1'b1;
      r_sdi <= '0;
      r_sh <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt <= '0;
      r_pend_words <= '0;
      r_pend_valid <= 1'b0;
      r_cfg_buf <= '0;
      r_cfg_pending <= 1'b0;
      r_send_d <= 1'b0;
      r_last_sent <= '0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_sclk <= (w_div_nxt >= DIV_HALF);
      r_send_d <= configuration_send;

      if (cfg_tvalid) begin
        r_cfg_buf <= cfg_tdata;
      end
      if (configuration_mode && w_send_rise) begin
        r_cfg_pending <= 1'b1;
      end else if (w_take_cfg) begin
        r_cfg_pending <= 1'b0;
      end

      // A consume in the same cycle frees the slot, so that is not a drop.
      if (w_accept) begin
        r_pend_words <= w_s_words;
        r_pend_valid <= 1'b1;
        if (r_pend_valid && !w_take_strm) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (w_take_strm) begin
        r_pend_valid <= 1'b0;
      end

      if (w_load) begin
        r_last_sent <= w_sel_words;
        r_sh <= w_ld_sh;
        r_sdi <= w_ld_msb;
        r_sync_n <= 1'b0;
        r_bitcnt <= BW'(WW - 1);
      end else if (w_shift) begin
        r_sh <= w_sh_nxt;
        r_sdi <= w_sh_msb;
        r_bitcnt <= r_bitcnt - BW'(1);
      end else if (w_end) begin
        r_sync_n <= 1'b1;
        r_sdi <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_gapcnt <= GW'(SYNC_GAP - 1);
      end else if (w_gap_dec) begin
        r_gapcnt <= r_gapcnt - GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_spi_dac_multi.sv
// Bench for axis_spi_dac_multi: a default instance and a fast 2-channel instance,
// SPI frames decoded off the pins and checked against a queue of expected words.
module tb_axis_spi_dac_multi;

  localparam int WW = 24;

  typedef logic [4*WW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #4 clk = ~clk;

  logic [127:0] s0_tdata;
  logic s0_tvalid;
  logic s0_tready;
  logic [95:0] c0_tdata;
  logic c0_tvalid;
  logic mode0;
  logic send0;
  logic sclk0;
  logic sync0;
  logic [3:0] sdi0;
  logic busy0;
  logic [15:0] fc0;
  logic [15:0] dc0;

  logic [63:0] s1_tdata;
  logic s1_tvalid;
  logic s1_tready;
  logic [47:0] c1_tdata;
  logic c1_tvalid;
  logic mode1;
  logic send1;
  logic sclk1;
  logic sync1;
  logic [1:0] sdi1;
  logic busy1;
  logic [15:0] fc1;
  logic [15:0] dc1;

  axis_spi_dac_multi u_dut0 (
    .a_clk(clk),
    .a_rst(rst),
    .s_axis_tdata(s0_tdata),
    .s_axis_tvalid(s0_tvalid),
    .s_axis_tready(s0_tready),
    .cfg_tdata(c0_tdata),
    .cfg_tvalid(c0_tvalid),
    .configuration_mode(mode0),
    .configuration_send(send0),
    .dac_sclk(sclk0),
    .dac_sync_n(sync0),
    .dac_sdi(sdi0),
    .busy(busy0),
    .frame_count(fc0),
    .drop_count(dc0)
  );

  axis_spi_dac_multi #(
    .NUM_DAC(2),
    .CLK_DIV(2),
    .SYNC_GAP(1),
    .SKIP_UNCHANGED(1'b0)
  ) u_dut1 (
    .a_clk(clk),
    .a_rst(rst),
    .s_axis_tdata(s1_tdata),
    .s_axis_tvalid(s1_tvalid),
    .s_axis_tready(s1_tready),
    .cfg_tdata(c1_tdata),
    .cfg_tvalid(c1_tvalid),
    .configuration_mode(mode1),
    .configuration_send(send1),
    .dac_sclk(sclk1),
    .dac_sync_n(sync1),
    .dac_sdi(sdi1),
    .busy(busy1),
    .frame_count(fc1),
    .drop_count(dc1)
  );

  int vectors = 0;
  int miscompares = 0;

  frame_t q0[$];
  frame_t q1[$];

  logic p_sclk[2];
  logic p_sync[2];
  frame_t cap[2];
  int nbits[2];
  int lowlen[2];
  int highlen[2];
  int last_high[2];
  int period[2];
  longint last_fall[2];
  longint cyc = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input logic sck,
                          input logic syn, input logic [3:0] sdi,
                          input int n, input int div);
    frame_t e;
    int qs;
    if (rst) begin
      p_sync[d] = 1'b1;
      p_sclk[d] = sck;
      nbits[d] = 0;
      lowlen[d] = 0;
      highlen[d] = 0;
      return;
    end
    if (p_sync[d] && !syn) begin
      period[d] = int'(cyc - last_fall[d]);
      last_fall[d] = cyc;
      last_high[d] = highlen[d];
      nbits[d] = 0;
      lowlen[d] = 0;
      cap[d] = '0;
    end
    if (!p_sync[d] && syn) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame dut%0d: got 0x%0h, required none",
                 d, cap[d]);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("dut%0d_frame_bits", d), nbits[d], WW);
        chk($sformatf("dut%0d_sync_low_cycles", d), lowlen[d], WW * div);
        for (int k = 0; k < n; k++) begin
          chk($sformatf("dut%0d_ch%0d_word", d, k),
              cap[d][k*WW +: WW], e[k*WW +: WW]);
        end
      end
      highlen[d] = 0;
    end
    if (!syn) begin
      lowlen[d]++;
      if (p_sclk[d] && !sck) begin
        for (int k = 0; k < n; k++) begin
          cap[d][k*WW +: WW] = {cap[d][k*WW +: WW-1], sdi[k]};
        end
        nbits[d]++;
      end
    end else begin
      highlen[d]++;
    end
    p_sync[d] = syn;
    p_sclk[d] = sck;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_step(0, sclk0, sync0, sdi0, 4, 4);
    mon_step(1, sclk1, sync1, {2'b00, sdi1}, 2, 2);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send0_s(input logic [127:0] t);
    s0_tdata = t;
    s0_tvalid = 1'b1;
    tick();
    s0_tvalid = 1'b0;
  endtask

  task automatic send1_s(input logic [63:0] t);
    s1_tdata = t;
    s1_tvalid = 1'b1;
    tick();
    s1_tvalid = 1'b0;
  endtask

  task automatic wait_fc(input int d, input int tgt, input int maxc);
    int c = 0;
    while ((((d == 0) ? fc0 : fc1) < 16'(tgt)) && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("dut%0d_wait_frames_%0d", d, tgt), c < maxc, 1);
  endtask

  task automatic wait_low(input int d, input int maxc);
    int c = 0;
    while (((d == 0) ? sync0 : sync1) && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("dut%0d_wait_sync_low", d), c < maxc, 1);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (busy0 && c < maxc) begin
      tick();
      c++;
    end
    chk("dut0_wait_idle", c < maxc, 1);
  endtask

  initial begin
    int lat;
    p_sync[0] = 1'b1;
    p_sync[1] = 1'b1;
    last_fall[0] = 0;
    last_fall[1] = 0;
    s0_tdata = '0;
    s0_tvalid = 1'b0;
    c0_tdata = '0;
    c0_tvalid = 1'b0;
    mode0 = 1'b0;
    send0 = 1'b0;
    s1_tdata = '0;
    s1_tvalid = 1'b0;
    c1_tdata = '0;
    c1_tvalid = 1'b0;
    mode1 = 1'b0;
    send1 = 1'b0;

    repeat (3) tick();
    chk("rst_sclk", sclk0, 0);
    chk("rst_sync_n", sync0, 1);
    chk("rst_sdi", sdi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_tready", s0_tready, 0);
    chk("rst_frame_count", fc0, 0);
    chk("rst_drop_count", dc0, 0);
    rst = 1'b0;
    tick();
    chk("tready_after_rst", s0_tready, 1);
    chk("tready1_after_rst", s1_tready, 1);

    // basic frame
    q0.push_back({24'h100000, 24'h100000, 24'h100000, 24'h1ABCDE});
    send0_s({32'h0, 32'h0, 32'h0, 32'hABCDE000});
    lat = 0;
    while (sync0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("accept_to_sync_latency_le5", lat <= 5, 1);
    chk("busy_in_frame", busy0, 1);
    wait_fc(0, 1, 400);
    chk("basic_frame_count", fc0, 1);
    chk("basic_drop_count", dc0, 0);

    // latest sample wins
    wait_idle(200);
    q0.push_back({24'h144444, 24'h133333, 24'h122222, 24'h111111});
    send0_s({32'h44444000, 32'h33333000, 32'h22222000, 32'h11111000});
    wait_low(0, 20);
    send0_s({4{32'hAAAAA000}});
    q0.push_back({24'h1FFFFF, 24'h10000F, 24'h19ABCD, 24'h112345});
    send0_s({32'hFFFFFFFF, 32'h0000F000, 32'h9ABCDEF0, 32'h12345678});
    chk("latest_drop_count", dc0, 1);
    wait_fc(0, 3, 400);
    chk("latest_frame_count", fc0, 3);
    chk("frame_period_104", period[0], 104);

    // unchanged sample is suppressed
    wait_idle(200);
    send0_s({32'hFFFFFFFF, 32'h0000F000, 32'h9ABCDEF0, 32'h12345678});
    repeat (200) tick();
    chk("suppressed_frame_count", fc0, 3);
    chk("suppressed_busy", busy0, 0);
    chk("suppressed_drop_count", dc0, 1);

    // config path
    mode0 = 1'b1;
    tick();
    chk("cfg_mode_tready", s0_tready, 0);
    c0_tdata = {24'hFFFFFF, 24'h0ABCDE, 24'h300001, 24'h200012};
    c0_tvalid = 1'b1;
    s0_tdata = {4{32'h77777000}};
    s0_tvalid = 1'b1;
    tick();
    c0_tvalid = 1'b0;
    s0_tvalid = 1'b0;
    q0.push_back({24'hFFFFFF, 24'h0ABCDE, 24'h300001, 24'h200012});
    send0 = 1'b1;
    wait_fc(0, 4, 300);
    repeat (200) tick();
    chk("cfg_held_send_one_frame", fc0, 4);
    chk("cfg_mode_tready_held", s0_tready, 0);
    send0 = 1'b0;
    mode0 = 1'b0;
    repeat (150) tick();
    chk("cfg_mode_stream_ignored", fc0, 4);
    send0 = 1'b1;
    tick();
    send0 = 1'b0;
    tick();
    mode0 = 1'b1;
    repeat (150) tick();
    chk("send_in_stream_mode_ignored", fc0, 4);
    mode0 = 1'b0;
    tick();

    // reset in the middle of a frame
    send0_s({4{32'h55555000}});
    wait_low(0, 20);
    repeat (40) tick();
    chk("midrst_in_frame", sync0, 0);
    rst = 1'b1;
    tick();
    chk("midrst_sync_n", sync0, 1);
    chk("midrst_sclk", sclk0, 0);
    chk("midrst_sdi", sdi0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_frame_count", fc0, 0);
    chk("midrst_drop_count", dc0, 0);
    rst = 1'b0;
    tick();
    q0.push_back({4{24'h155555}});
    send0_s({4{32'h55555000}});
    wait_fc(0, 1, 400);
    chk("post_rst_frame_count", fc0, 1);

    // fast two-channel instance, no suppression
    q1.push_back({48'h0, 24'h10F0F0, 24'h1CAFEB});
    q1.push_back({48'h0, 24'h10F0F0, 24'h1CAFEB});
    send1_s({32'h0F0F0000, 32'hCAFEB000});
    wait_low(1, 20);
    chk("dut1_busy", busy1, 1);
    send1_s({32'h0F0F0000, 32'hCAFEB000});
    wait_fc(1, 2, 300);
    chk("dut1_frame_count", fc1, 2);
    chk("dut1_frame_period_50", period[1], 50);
    chk("dut1_gap_cycles_2", last_high[1], 2);
    chk("dut1_drop_count", dc1, 0);

    repeat (20) tick();
    chk("dut0_expected_all_seen", q0.size(), 0);
    chk("dut1_expected_all_seen", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
